// File: rtl/bsg_manycore_host_arb_pkg.sv
// rtl/bsg_manycore_host_arb_pkg.sv - shared types and constants for the host request arbiter
package bsg_manycore_host_arb_pkg;

  localparam int host_arb_reg_id_width_gp = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } host_arb_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// rtl/bsg_arb_round_robin.sv - round-robin arbiter whose pointer moves only when a grant is taken
module bsg_arb_round_robin #(
  parameter int width_p = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [width_p-1:0]         reqs,
  input  logic                       take,
  output logic [width_p-1:0]         grants,
  output logic [$clog2(width_p)-1:0] grant_idx,
  output logic                       any_req
);

  localparam int idx_w = $clog2(width_p);

  logic [idx_w-1:0] last;
  logic [idx_w-1:0] cand_idx;
  logic             found;

  // Scan requesters starting just after the last-granted one; first hit wins.
  always_comb begin
    grants    = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_idx  = '0;
    for (int k = 1; k <= width_p; k++) begin
      cand_idx = idx_w'((int'(last) + k) % width_p);
      if (!found && reqs[cand_idx]) begin
        found             = 1'b1;
        grants[cand_idx]  = 1'b1;
        grant_idx         = cand_idx;
      end
    end
  end

  assign any_req = found;

  // Remember the winner only when the grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= idx_w'(width_p - 1);
    end else if (take && found) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/bsg_manycore_host_req_arbiter.sv
// rtl/bsg_manycore_host_req_arbiter.sv - shares the host endpoint among requesters; BSG_HOST_ARB_PROFILE_EN adds grant/stall counters
module bsg_manycore_host_req_arbiter
  import bsg_manycore_host_arb_pkg::*;
#(
  parameter int num_req_p         = 4,
  parameter int packet_width_p    = 128,
  parameter int reg_id_lsb_p      = 0,
  parameter int data_width_p      = 32,
  parameter int max_out_credits_p = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p*packet_width_p-1:0]    req_packet_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  output logic                                   out_v_o,
  output logic [packet_width_p-1:0]              out_packet_o,
  input  logic                                   out_ready_i,
  input  logic                                   returned_v_i,
  input  logic [4:0]                             returned_reg_id_i,
  input  logic [data_width_p-1:0]                returned_data_i,
  output logic                                   returned_yumi_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  output logic [data_width_p-1:0]                resp_data_o,
  input  logic [num_req_p-1:0]                   resp_ready_i,
  input  logic                                   drain_i,
  output logic                                   drained_o,
  output logic [$clog2(max_out_credits_p+1)-1:0] credits_o,
  output logic                                   error_o
);

  localparam int idx_w    = $clog2(num_req_p);
  localparam int credit_w = $clog2(max_out_credits_p + 1);
  localparam int id_w     = host_arb_reg_id_width_gp;
  localparam logic [credit_w-1:0]       credit_max = credit_w'(max_out_credits_p);
  localparam logic [packet_width_p-1:0] id_mask    = packet_width_p'({id_w{1'b1}}) << reg_id_lsb_p;

  host_arb_state_e             state, state_n;
  logic [credit_w-1:0]         credits;
  logic                        out_v;
  logic [packet_width_p-1:0]   out_packet;
  logic                        error;
  logic                        send, ret, can_grant, any_req, grant;
  logic [num_req_p-1:0]        grants;
  logic [idx_w-1:0]            grant_idx;
  logic [packet_width_p-1:0]   sel_packet, stamped;
  logic                        id_ok, sel_ready;

  assign send = out_v & out_ready_i;

  // The registered-but-unsent packet already owns a credit, so it is subtracted here.
  assign can_grant = (state == RUN) && (credits > credit_w'(out_v)) && (!out_v || out_ready_i);
  assign grant     = can_grant & any_req;

  bsg_arb_round_robin #(
    .width_p (num_req_p)
  ) rr (
    .clk       (clk_i),
    .rst_n     (reset_n_i),
    .reqs      (req_v_i),
    .take      (can_grant),
    .grants    (grants),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign req_ready_o = can_grant ? grants : '0;

  assign sel_packet = req_packet_i[grant_idx*packet_width_p +: packet_width_p];
  assign stamped    = (sel_packet & ~id_mask) | (packet_width_p'(grant_idx) << reg_id_lsb_p);

  // Route the returned response to the requester named by its reg_id.
  always_comb begin
    resp_v_o  = '0;
    sel_ready = 1'b0;
    id_ok     = returned_reg_id_i < id_w'(num_req_p);
    for (int i = 0; i < num_req_p; i++) begin
      if (returned_reg_id_i == id_w'(i)) begin
        resp_v_o[i] = returned_v_i;
        sel_ready   = resp_ready_i[i];
      end
    end
  end

  // An unroutable response is swallowed so the endpoint never stalls on it.
  assign returned_yumi_o = returned_v_i & (id_ok ? sel_ready : 1'b1);
  assign resp_data_o     = returned_data_i;
  assign ret             = returned_v_i & returned_yumi_o;

  // Outstanding-credit counter; saturates at the maximum on a spurious return.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits <= credit_max;
    end else if (ret && !send) begin
      credits <= (credits == credit_max) ? credits : credits + 1'b1;
    end else if (send && !ret) begin
      credits <= credits - 1'b1;
    end
  end

  // Sticky error on bad reg_id or a return with nothing outstanding.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error <= 1'b0;
    end else if ((returned_v_i && !id_ok) || (ret && credits == credit_max)) begin
      error <= 1'b1;
    end
  end

  // One-entry output stage holding the stamped packet until the endpoint takes it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v      <= 1'b0;
      out_packet <= '0;
    end else if (grant) begin
      out_v      <= 1'b1;
      out_packet <= stamped;
    end else if (send) begin
      out_v      <= 1'b0;
    end
  end

  // Drain state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Drain sequencing: stop granting, wait for an empty stage and all credits home.
  always_comb begin
    state_n   = state;
    drained_o = 1'b0;
    case (state)
      RUN:     if (drain_i) state_n = DRAIN;
      DRAIN:   if (!out_v && credits == credit_max) state_n = DRAINED;
      DRAINED: begin
        drained_o = 1'b1;
        if (!drain_i) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign out_v_o      = out_v;
  assign out_packet_o = out_packet;
  assign credits_o    = credits;
  assign error_o      = error;

`ifdef BSG_HOST_ARB_PROFILE_EN
  logic [31:0] grant_count [num_req_p];
  logic [31:0] stall_count;

  // Saturating per-requester grant counts and credit-starvation stall cycles.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_req_p; i++) grant_count[i] <= '0;
      stall_count <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (grant && grants[i] && grant_count[i] != '1) grant_count[i] <= grant_count[i] + 1'b1;
      end
      if ((|req_v_i) && state == RUN && credits <= credit_w'(out_v) && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

  final begin
    for (int i = 0; i < num_req_p; i++) $display("host_arb grants[%0d] = %0d", i, grant_count[i]);
    $display("host_arb credit stalls = %0d", stall_count);
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_host_req_arbiter.sv
// tb/tb_bsg_manycore_host_req_arbiter.sv - self-checking bench for the host request arbiter
module tb_bsg_manycore_host_req_arbiter;

  localparam int N = 4, PW = 128, LSB = 0, DW = 32, MAX = 16, CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_v, req_ready, resp_v, resp_ready;
  logic [PW-1:0]   pkts [N];
  logic [N*PW-1:0] req_packet;
  logic            out_v, out_ready, returned_v, returned_yumi, drain, drained, error;
  logic [PW-1:0]   out_packet;
  logic [4:0]      returned_reg_id;
  logic [DW-1:0]   returned_data, resp_data;
  logic [CW-1:0]   credits;

  always_comb for (int i = 0; i < N; i++) req_packet[i*PW +: PW] = pkts[i];

  bsg_manycore_host_req_arbiter #(
    .num_req_p(N), .packet_width_p(PW), .reg_id_lsb_p(LSB), .data_width_p(DW), .max_out_credits_p(MAX)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(req_v), .req_packet_i(req_packet), .req_ready_o(req_ready),
    .out_v_o(out_v), .out_packet_o(out_packet), .out_ready_i(out_ready),
    .returned_v_i(returned_v), .returned_reg_id_i(returned_reg_id), .returned_data_i(returned_data),
    .returned_yumi_o(returned_yumi),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_ready_i(resp_ready),
    .drain_i(drain), .drained_o(drained), .credits_o(credits), .error_o(error)
  );

  int checks = 0, errors = 0;

  // Reference model: credits, output slot, last winner, drain phase (0 run, 1 draining, 2 drained).
  int            m_credits, m_last, m_state;
  bit            m_out_v, m_err;
  logic [PW-1:0] m_out_pkt;
  int            sent_ids[$];
  int            dut_grants[$];
  logic [N-1:0]  e_req_ready, e_resp_v;
  bit            e_yumi, e_send, e_ret;
  int            e_g;

  function automatic logic [PW-1:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_credits = MAX; m_last = N - 1; m_state = 0;
    m_out_v = 0; m_err = 0; m_out_pkt = '0;
    sent_ids.delete();
  endtask

  task automatic model_comb();
    int avail;
    e_send = m_out_v && out_ready;
    avail = m_credits - (m_out_v ? 1 : 0);
    e_req_ready = '0;
    e_g = -1;
    if (m_state == 0 && avail > 0 && (!m_out_v || e_send)) begin
      for (int k = 1; k <= N; k++) begin
        int r;
        r = (m_last + k) % N;
        if (e_g < 0 && req_v[r]) e_g = r;
      end
    end
    if (e_g >= 0) e_req_ready[e_g] = 1'b1;
    e_resp_v = '0;
    e_yumi = 0;
    if (returned_v) begin
      if (returned_reg_id < N) begin
        e_resp_v[returned_reg_id] = 1'b1;
        e_yumi = resp_ready[returned_reg_id];
      end else begin
        e_yumi = 1;
      end
    end
    e_ret = returned_v && e_yumi;
  endtask

  task automatic model_update();
    int old_credits;
    bit old_out_v;
    old_credits = m_credits;
    old_out_v = m_out_v;
    if (e_ret && m_credits == MAX) m_err = 1;
    if (returned_v && returned_reg_id >= N) m_err = 1;
    m_credits = m_credits - int'(e_send) + int'(e_ret);
    if (m_credits > MAX) m_credits = MAX;
    if (e_send) sent_ids.push_back(int'(m_out_pkt[LSB +: 5]));
    if (e_g >= 0) begin
      m_out_pkt = pkts[e_g];
      m_out_pkt[LSB +: 5] = 5'(e_g);
      m_out_v = 1;
      m_last = e_g;
    end else if (e_send) begin
      m_out_v = 0;
    end
    case (m_state)
      0:       if (drain) m_state = 1;
      1:       if (!old_out_v && old_credits == MAX) m_state = 2;
      default: if (!drain) m_state = 0;
    endcase
  endtask

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic refresh_granted();
    for (int i = 0; i < N; i++) if (e_req_ready[i]) pkts[i] = rand_pkt();
  endtask

  task automatic log_grant();
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
  endtask

  task automatic apply_reset();
    req_v = '0; out_ready = 0; returned_v = 0; returned_reg_id = '0;
    returned_data = '0; resp_ready = '0; drain = 0;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    settle();
    checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got %b want 0", out_v); end
    checks++; if (out_packet !== '0) begin errors++; $display("FAIL reset_out_packet got %h want 0", out_packet); end
    checks++; if (credits !== CW'(MAX)) begin errors++; $display("FAIL reset_credits got %0d want %0d", credits, MAX); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got %b want 0", drained); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (req_ready !== '0 || resp_v !== '0 || returned_yumi !== 1'b0) begin
      errors++; $display("FAIL reset_comb got ready=%b resp_v=%b yumi=%b want 0", req_ready, resp_v, returned_yumi);
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
    req_v = 4'b0101; out_ready = 1; dut_grants.delete();
    for (int c = 0; c < 24; c++) begin
      settle();
      log_grant();
      checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL alt_ready c=%0d got %b want %b", c, req_ready, e_req_ready); end
      checks++; if (out_v !== m_out_v || (m_out_v && out_packet !== m_out_pkt)) begin
        errors++; $display("FAIL alt_out c=%0d got v=%b pkt=%h want v=%b pkt=%h", c, out_v, out_packet, m_out_v, m_out_pkt);
      end
      tick();
      refresh_granted();
    end
    checks++; if (dut_grants.size() != 16) begin errors++; $display("FAIL alt_count got %0d want 16", dut_grants.size()); end
    foreach (dut_grants[i]) begin
      checks++; if (dut_grants[i] != (i % 2) * 2) begin errors++; $display("FAIL alt_order idx=%0d got %0d want %0d", i, dut_grants[i], (i % 2) * 2); end
    end
    settle();
    checks++; if (credits !== '0) begin errors++; $display("FAIL alt_credits got %0d want 0", credits); end
    checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL alt_idle got %b want 0", out_v); end
  endtask

  task automatic test_returns();
    int pulses;
    pulses = 0;
    req_v = '0; returned_v = 1; returned_reg_id = 5'd2; resp_ready = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      returned_data = $urandom();
      settle();
      checks++; if (resp_v !== 4'b0100 || returned_yumi !== 1'b1 || resp_data !== returned_data) begin
        errors++; $display("FAIL ret_route c=%0d got resp_v=%b yumi=%b data=%h want 0100 1 %h", c, resp_v, returned_yumi, resp_data, returned_data);
      end
      if (resp_v[2]) pulses++;
      tick();
    end
    returned_v = 0;
    settle();
    checks++; if (pulses != 3) begin errors++; $display("FAIL ret_pulses got %0d want 3", pulses); end
    checks++; if (credits !== CW'(3)) begin errors++; $display("FAIL ret_credits got %0d want 3", credits); end
    req_v = 4'b0101; dut_grants.delete();
    for (int c = 0; c < 8; c++) begin
      settle();
      log_grant();
      checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL ret_ready c=%0d got %b want %b", c, req_ready, e_req_ready); end
      tick();
      refresh_granted();
    end
    settle();
    checks++; if (dut_grants.size() != 3) begin errors++; $display("FAIL ret_grants got %0d want 3", dut_grants.size()); end
    checks++; if (credits !== '0) begin errors++; $display("FAIL ret_exhaust got %0d want 0", credits); end
  endtask

  task automatic test_same_cycle();
    req_v = '0; returned_v = 1; returned_reg_id = 5'd0; resp_ready = '1;
    for (int c = 0; c < 5; c++) begin settle(); tick(); end
    returned_v = 0; req_v = 4'b0001;
    settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL same_grant got %b want 0001", req_ready); end
    tick();
    req_v = '0; returned_v = 1; out_ready = 1;
    settle();
    checks++; if (out_v !== 1'b1 || credits !== CW'(5)) begin errors++; $display("FAIL same_before got v=%b cr=%0d want 1 5", out_v, credits); end
    tick();
    returned_v = 0;
    settle();
    checks++; if (credits !== CW'(5)) begin errors++; $display("FAIL same_after got %0d want 5", credits); end
  endtask

  task automatic test_drain();
    apply_reset();
    out_ready = 1; req_v = 4'b1111;
    for (int c = 0; c < 4; c++) begin settle(); tick(); refresh_granted(); end
    req_v = '0;
    settle(); tick();
    settle();
    checks++; if (credits !== CW'(12) || out_v !== 1'b0) begin errors++; $display("FAIL drain_setup got cr=%0d v=%b want 12 0", credits, out_v); end
    drain = 1;
    settle(); tick();
    req_v = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (req_ready !== '0 || drained !== 1'b0) begin errors++; $display("FAIL drain_hold c=%0d got ready=%b drained=%b want 0 0", c, req_ready, drained); end
      tick();
    end
    returned_v = 1; resp_ready = '1;
    for (int c = 0; c < 4; c++) begin
      returned_reg_id = 5'(c);
      settle();
      checks++; if (returned_yumi !== 1'b1 || drained !== 1'b0) begin errors++; $display("FAIL drain_ret c=%0d got yumi=%b drained=%b want 1 0", c, returned_yumi, drained); end
      tick();
    end
    returned_v = 0;
    settle();
    checks++; if (credits !== CW'(MAX) || drained !== 1'b0) begin errors++; $display("FAIL drain_early got cr=%0d drained=%b want 16 0", credits, drained); end
    tick();
    settle();
    checks++; if (drained !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL drain_done got drained=%b ready=%b want 1 0", drained, req_ready); end
    drain = 0;
    settle();
    checks++; if (drained !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL drain_release got drained=%b ready=%b want 1 0", drained, req_ready); end
    tick();
    settle();
    checks++; if (drained !== 1'b0 || req_ready !== 4'b0001) begin errors++; $display("FAIL drain_resume got drained=%b ready=%b want 0 0001", drained, req_ready); end
    tick();
    req_v = '0;
  endtask

  task automatic test_bad_id();
    settle(); tick();
    returned_v = 1; returned_reg_id = 5'd7; resp_ready = '0;
    settle();
    checks++; if (returned_yumi !== 1'b1 || resp_v !== '0) begin errors++; $display("FAIL bad_route got yumi=%b resp_v=%b want 1 0", returned_yumi, resp_v); end
    tick();
    returned_v = 0;
    settle();
    checks++; if (credits !== CW'(MAX) || error !== 1'b1) begin errors++; $display("FAIL bad_credit got cr=%0d err=%b want 16 1", credits, error); end
    for (int c = 0; c < 3; c++) tick();
    settle();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b want 1", error); end
  endtask

  task automatic test_credit_saturate();
    apply_reset();
    settle();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL sat_cleared got %b want 0", error); end
    returned_v = 1; returned_reg_id = 5'd1; resp_ready = 4'b0010;
    settle();
    checks++; if (returned_yumi !== 1'b1 || resp_v !== 4'b0010) begin errors++; $display("FAIL sat_route got yumi=%b resp_v=%b want 1 0010", returned_yumi, resp_v); end
    tick();
    returned_v = 0;
    settle();
    checks++; if (credits !== CW'(MAX) || error !== 1'b1) begin errors++; $display("FAIL sat_state got cr=%0d err=%b want 16 1", credits, error); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_v = 4'b1111; out_ready = 1;
    for (int c = 0; c < 3; c++) begin settle(); tick(); refresh_granted(); end
    settle();
    checks++; if (out_v !== 1'b1) begin errors++; $display("FAIL areset_pre got %b want 1", out_v); end
    #2 rst_n = 1'b0;
    req_v = '0;
    #1;
    checks++; if (out_v !== 1'b0 || credits !== CW'(MAX)) begin errors++; $display("FAIL areset_now got v=%b cr=%0d want 0 16", out_v, credits); end
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    req_v = 4'b1111;
    settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL areset_prio got %b want 0001", req_ready); end
    tick();
    req_v = '0;
    settle(); tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < N; i++) pkts[i] = rand_pkt();
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      resp_ready = 4'($urandom());
      if (!returned_v && sent_ids.size() > 0 && $urandom_range(0, 2) == 0) begin
        returned_v = 1;
        returned_reg_id = 5'(sent_ids.pop_front());
        returned_data = $urandom();
      end
      settle();
      checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, e_req_ready); end
      checks++; if (out_v !== m_out_v || (m_out_v && out_packet !== m_out_pkt)) begin
        errors++; $display("FAIL rnd_out c=%0d got v=%b pkt=%h want v=%b pkt=%h", c, out_v, out_packet, m_out_v, m_out_pkt);
      end
      checks++; if (credits !== CW'(m_credits) || error !== m_err) begin errors++; $display("FAIL rnd_credits c=%0d got cr=%0d err=%b want %0d %b", c, credits, error, m_credits, m_err); end
      checks++; if (resp_v !== e_resp_v || returned_yumi !== e_yumi || (returned_v && resp_data !== returned_data)) begin
        errors++; $display("FAIL rnd_resp c=%0d got v=%b yumi=%b want v=%b yumi=%b", c, resp_v, returned_yumi, e_resp_v, e_yumi);
      end
      tick();
      if (e_ret) returned_v = 0;
      for (int i = 0; i < N; i++) begin
        if (e_req_ready[i]) begin
          req_v[i] = 1'($urandom_range(0, 1));
          pkts[i] = rand_pkt();
        end else if (!req_v[i]) begin
          req_v[i] = ($urandom_range(0, 2) == 0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pkts[i] = '0;
    test_reset();
    test_alternate();
    test_returns();
    test_same_cycle();
    test_drain();
    test_bad_id();
    test_credit_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
